instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
Multi-cycle program sequencer for the 9-bit core: owns the program counter, runs the start/done handshake with the testbench, and stalls the pipeline-less datapath for data-memory accesses. It sits between the instruction ROM (driven by pc) and the decode/control logic. It consumes the decoder's branch/memory/writeback strobes and produces the architectural commit strobes.

Parameters:
PC_W, 10, program counter width; instruction ROM depth is 2^PC_W.
MEM_LAT, 2, extra stall cycles for a data-memory access; the legal range is 0..7.
CYC_W, 16, width of the saturating cycle counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  single-cycle pulse that launches execution from pc 0; honoured only in IDLE or DONE.
done  output  1  high while in DONE; held until the next accepted start or reset.
busy  output  1  high in RUN or WAIT.
pc  output  PC_W  address to the instruction ROM.
instr_valid  output  1  high when the ROM word at pc is being executed this cycle (RUN only).
branch_enable  input  1  decoder branch-taken strobe, already qualified by equal/lessThan.
branch_target  input  PC_W  absolute target, read from the branch LUT.
mem_read  input  1  decoder memory-read strobe, covering load and LUT-memory reads.
mem_write  input  1  decoder store strobe.
reg_write  input  1  decoder register-write strobe.
halt  input  1  decoded halt instruction.
commit_reg  output  1  register-file write enable as gated by the sequencer.
commit_mem  output  1  data-memory write enable as gated by the sequencer.
cycle_count  output  CYC_W  number of cycles spent in RUN+WAIT since the last accepted start; saturates at all-ones.

Behaviour:
- States: IDLE, RUN, WAIT, DONE. Encoding is free.
- Reset (async, any state, including mid-WAIT) forces:
  - state=IDLE, pc=0, wait counter=0, cycle_count=0;
  - done=0, busy=0, instr_valid=0, commit_reg=0, commit_mem=0.
- IDLE: pc holds at 0. On start=1 the next state is RUN, pc=0 and cycle_count=0.
- RUN: instr_valid=1 and busy=1. Decoder inputs are sampled only in this state. Priority order:
  1. halt=1: next state DONE; pc holds; no commits.
  2. mem_read or mem_write with MEM_LAT>0: next state WAIT, wait counter=MEM_LAT-1, pc holds. commit_mem and commit_reg are 0 this cycle; branch_enable is ignored.
  3. mem_read or mem_write with MEM_LAT=0: behaves as a normal instruction. commit_mem=mem_write and commit_reg=reg_write in this cycle.
  4. Otherwise:
     - commit_reg=reg_write, commit_mem=0;
     - pc <= branch_target if branch_enable, else pc+1;
     - pc+1 wraps from 2^PC_W-1 to 0 silently.
- WAIT: busy=1, instr_valid=0, pc holds at the memory instruction. The decoder strobes are held stable by the caller because pc is unchanged, so the sequencer uses their live values.
  - Counter>0: decrement; commit_reg=0, commit_mem=0.
  - Counter=0: the final cycle. commit_mem=mem_write and commit_reg=reg_write (load writeback). Then pc <= pc+1 (with wrap) and next state RUN.
- DONE: done=1, busy=0, pc holds at the halt address. start=1 triggers the same restart as from IDLE; done drops on the next cycle.
- start is ignored in RUN and WAIT.
- cycle_count increments on every clock edge where state is RUN or WAIT, and stops at 2^CYC_W-1. It holds its value in DONE for readout.
- The commit outputs are combinational from state and inputs. Every state register is updated on the rising clk edge only.
- A single-cycle instruction occupies 1 cycle. A memory instruction occupies 1+MEM_LAT cycles.

Test Plan:
- Reset mid-WAIT (MEM_LAT=2, assert reset during the first WAIT cycle) -> state=IDLE, pc=0, busy=0, commit_mem=0 immediately, without waiting for a clock edge.
- start, then 3 ALU ops with reg_write=1, then halt at pc=3 -> pc sequence 0,1,2,3; commit_reg high on 3 cycles; done=1 on cycle 5 with pc=3 held; cycle_count=4.
- Load at pc=0 with MEM_LAT=2 (mem_read=1, reg_write=1) -> pc=0 for 3 cycles; commit_reg only on the 3rd cycle; pc=1 on the 4th cycle. Repeat with MEM_LAT=0 -> commit on the 1st cycle, pc=1 on the 2nd.
- branch_enable=1 with branch_target=0x2A at pc=5 -> next pc=0x2A. With branch_enable=1 on a store instruction -> the branch is ignored and pc=6 after the wait.
- PC_W=4, straight-line code with no halt -> pc 14, 15, 0: silent wrap, busy remains 1.
- start pulse during RUN -> ignored, pc continues. start in DONE -> pc=0, cycle_count=0, done falls on the next cycle; CYC_W=3 run of 10 cycles -> cycle_count=7 (saturated).

Source files
------------

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle program sequencer for the 9-bit core. It owns the program
// counter, runs the start/done handshake, and stalls the datapath while a
// data-memory access completes. It sits between the instruction ROM (fed by
// pc) and the decode/control logic. It turns the decoder strobes into the
// architectural commit strobes.
//
// Parameters
//   PC_W     program counter width (ROM depth is 2**PC_W)
//   MEM_LAT  extra stall cycles per data-memory access, legal range 0..7
//   CYC_W    width of the saturating cycle counter
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   start          launch pulse, accepted only when idle or done
//   done           high while finished (held until restart or reset)
//   busy           high while executing or stalled on memory
//   pc             instruction ROM address
//   instr_valid    the ROM word at pc is being executed this cycle
//   branch_enable  decoder branch-taken strobe
//   branch_target  absolute branch target
//   mem_read       decoder memory-read strobe
//   mem_write      decoder store strobe
//   reg_write      decoder register-write strobe
//   halt           decoded halt instruction
//   commit_reg     gated register-file write enable
//   commit_mem     gated data-memory write enable
//   cycle_count    cycles spent executing since the last start (saturating)
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int PC_W    = 10,
  parameter int MEM_LAT = 2,
  parameter int CYC_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             done,
  output logic             busy,
  output logic [PC_W-1:0]  pc,
  output logic             instr_valid,
  input  logic             branch_enable,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             halt,
  output logic             commit_reg,
  output logic             commit_mem,
  output logic [CYC_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_t;

  // A memory access only stalls when there is latency to cover.
  localparam bit        HAS_WAIT  = (MEM_LAT > 0);
  // The wait counter counts down to zero, so it starts one below the
  // number of stall cycles.
  localparam logic [2:0] WAIT_INIT = HAS_WAIT ? 3'(MEM_LAT - 1) : 3'd0;

  state_t             state_reg, state_next;
  logic [PC_W-1:0]    pc_reg, pc_next;
  logic [2:0]         wait_cnt_reg, wait_cnt_next;
  logic [CYC_W-1:0]   cyc_reg, cyc_next;

  logic [PC_W-1:0]    pc_inc;
  logic [CYC_W-1:0]   cyc_inc;
  logic               mem_access;

  // Sequential pc step; overflow wraps silently to 0.
  assign pc_inc     = pc_reg + PC_W'(1);
  // Saturating increment: hold once every bit is set.
  assign cyc_inc    = (&cyc_reg) ? cyc_reg : cyc_reg + CYC_W'(1);
  assign mem_access = mem_read | mem_write;

  assign pc          = pc_reg;
  assign cycle_count = cyc_reg;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      pc_reg       <= '0;
      wait_cnt_reg <= '0;
      cyc_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      wait_cnt_reg <= wait_cnt_next;
      cyc_reg      <= cyc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    wait_cnt_next = wait_cnt_reg;
    cyc_next      = cyc_reg;
    done          = 1'b0;
    busy          = 1'b0;
    instr_valid   = 1'b0;
    commit_reg    = 1'b0;
    commit_mem    = 1'b0;

    case (state_reg)
      S_IDLE, S_DONE: begin
        done = (state_reg == S_DONE);
        if (start) begin
          state_next    = S_RUN;
          pc_next       = '0;
          wait_cnt_next = '0;
          cyc_next      = '0;
        end
      end

      S_RUN: begin
        busy        = 1'b1;
        instr_valid = 1'b1;
        cyc_next    = cyc_inc;
        if (halt) begin
          state_next = S_DONE;
        end else if (mem_access && HAS_WAIT) begin
          // Stall on the memory instruction; any branch request is dropped.
          state_next    = S_WAIT;
          wait_cnt_next = WAIT_INIT;
        end else begin
          // mem_write can only be high here when there is no memory latency,
          // in which case the store commits immediately.
          commit_reg = reg_write;
          commit_mem = mem_write;
          pc_next    = branch_enable ? branch_target : pc_inc;
        end
      end

      S_WAIT: begin
        busy     = 1'b1;
        cyc_next = cyc_inc;
        if (wait_cnt_reg == 3'd0) begin
          // Final stall cycle: the decoder still sees the memory instruction,
          // so its live strobes give the store enable and load writeback.
          commit_reg = reg_write;
          commit_mem = mem_write;
          pc_next    = pc_inc;
          state_next = S_RUN;
        end else begin
          wait_cnt_next = wait_cnt_reg - 3'd1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
